// File: rtl/shift_left_seq.sv
// shift_left_seq: multi-cycle logical left shifter, one bit per clock, with
// start/busy/done handshake plus carry (last bit out of MSB) and zero flags.
module shift_left_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [CNT_W-1:0] Shift,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ASL,
    output logic             carry_out,
    output logic             zero
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             accept;
    assign accept = (state == IDLE) && start;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (accept)                                  state_nx = (Shift != '0) ? SHIFT : DONE;
        else if (state == SHIFT && cnt == CNT_W'(1)) state_nx = DONE;
        else if (state == DONE)                      state_nx = IDLE;
    end
    // No early exit when sreg empties: latency depends only on the shift amount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            sreg  <= A;
            cnt   <= Shift;
            carry <= 1'b0;
        end else if (state == SHIFT) begin
            sreg  <= {sreg[WIDTH-2:0], 1'b0};
            carry <= sreg[WIDTH-1];
            cnt   <= cnt - CNT_W'(1);
        end
    end
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign ASL       = sreg;
    assign carry_out = carry;
    assign zero      = (sreg == '0);
endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq: directed cases plus random traffic checked every cycle
// against a timestamp-based reference of the shifter.
module tb_shift_left_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] A;
    logic [3:0] Shift;
    logic       busy;
    logic       done;
    logic [7:0] ASL;
    logic       carry_out;
    logic       zero;
    int n_chk = 0;
    int n_fail = 0;
    shift_left_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .Shift(Shift),
        .busy(busy), .done(done), .ASL(ASL), .carry_out(carry_out), .zero(zero)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string n, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
        end
    endtask
    // Reference: an op accepted at edge c is done in the cycle after edge c+Shift,
    // with result (A << Shift) and carry = bit WIDTH of the untruncated product.
    int         cyc = 0;
    bit         m_active;
    int         m_done_at;
    logic [7:0] m_asl;
    logic       m_carry;
    logic [8:0] w;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_asl    = 8'h00;
            m_carry  = 1'b0;
        end else begin
            cyc++;
            if ((!m_active || cyc - 1 > m_done_at) && start) begin
                w         = {1'b0, A} << Shift;
                m_active  = 1'b1;
                m_done_at = cyc + int'(Shift);
                m_asl     = w[7:0];
                m_carry   = w[8];
            end
        end
    end
    always @(negedge clk) begin
        bit be, de;
        be = rst_n && m_active && cyc <= m_done_at;
        de = rst_n && m_active && cyc == m_done_at;
        check("busy", int'(busy), int'(be));
        check("done", int'(done), int'(de));
        if (!be || de) begin
            check("ASL", int'(ASL), int'(rst_n ? m_asl : 8'h00));
            check("carry_out", int'(carry_out), int'(rst_n ? m_carry : 1'b0));
            check("zero", int'(zero), int'(rst_n ? (m_asl == 8'h00) : 1'b1));
        end
    end
    task automatic issue(input logic [7:0] a, input logic [3:0] s);
        @(posedge clk); #1;
        start = 1'b1; A = a; Shift = s;
        @(posedge clk); #1;
        start = 1'b0; A = 8'($urandom); Shift = 4'($urandom);
    endtask
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
    endtask
    task automatic expect_res(input string n, input int lat, input int elat,
                              input logic [7:0] ea, input logic ec, input logic ez);
        check({n, " latency"}, lat, elat);
        check({n, " ASL"}, int'(ASL), int'(ea));
        check({n, " carry"}, int'(carry_out), int'(ec));
        check({n, " zero"}, int'(zero), int'(ez));
    endtask
    task automatic op(input string n, input logic [7:0] a, input logic [3:0] s, input int elat,
                      input logic [7:0] ea, input logic ec, input logic ez);
        int c;
        issue(a, s);
        wait_done(1, c);
        expect_res(n, c, elat, ea, ec, ez);
    endtask
    initial begin
        int c, g, np;
        rst_n = 1'b0; start = 1'b0; A = 8'h00; Shift = 4'h0;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset ASL", int'(ASL), 0);
        check("reset carry", int'(carry_out), 0);
        check("reset zero", int'(zero), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        op("t1", 8'h81, 4'd1, 2, 8'h02, 1'b1, 1'b0);
        issue(8'h5A, 4'd0);
        check("t2 busy", int'(busy), 1);
        expect_res("t2", 1, 1, 8'h5A, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("t2 busy after", int'(busy), 0);
        op("t3a", 8'hFF, 4'd8, 9, 8'h00, 1'b1, 1'b1);
        op("t3b", 8'hFF, 4'd15, 16, 8'h00, 1'b0, 1'b1);
        issue(8'h0F, 4'd3);
        @(posedge clk); #1;
        start = 1'b1; A = 8'hFF; Shift = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, c);
        expect_res("t4", c, 4, 8'h78, 1'b0, 1'b0);
        np = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) np++;
        end
        check("t4 extra done", np, 0);
        check("t4 ASL held", int'(ASL), 8'h78);
        @(posedge clk); #1;
        start = 1'b1; A = 8'h01; Shift = 4'd7;
        @(posedge clk); #1;
        A = 8'h80; Shift = 4'd1;
        wait_done(1, c);
        expect_res("t5a", c, 8, 8'h80, 1'b0, 1'b0);
        g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while (!done && g < 40);
        start = 1'b0;
        check("t5 done gap", g, 3);
        check("t5b ASL", int'(ASL), 8'h00);
        check("t5b carry", int'(carry_out), 1);
        issue(8'hC3, 4'd10);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("t6 busy", int'(busy), 0);
        check("t6 done", int'(done), 0);
        check("t6 ASL", int'(ASL), 0);
        check("t6 zero", int'(zero), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        np = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) np++;
        end
        check("t6 no done", np, 0);
        op("t6 fresh", 8'h03, 4'd2, 3, 8'h0C, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            A     = 8'($urandom);
            Shift = 4'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
